// File: rtl/slc_pkg.sv
// Shared definitions for the set-associative SLC tag/state store.
// Includes CHI state encodings, state helpers and the lookup request/response records.
package slc_pkg;

    localparam logic [2:0] SLC_UC = 3'b100;
    localparam logic [2:0] SLC_UD = 3'b110;
    localparam logic [2:0] SLC_SC = 3'b000;
    localparam logic [2:0] SLC_SD = 3'b010;
    localparam logic [2:0] SLC_I  = 3'b001;

    localparam int SLC_ADDR_W  = 48;
    localparam int SLC_TXNID_W = 8;
    localparam int SLC_WAY_W   = 2;

    function automatic logic is_valid(input logic [2:0] s);
        return s != SLC_I;
    endfunction

    function automatic logic is_dirty(input logic [2:0] s);
        return s[1];
    endfunction

    function automatic logic is_unique(input logic [2:0] s);
        return s[2];
    endfunction

    function automatic int slc_tag_w(input int addr_w, input int set_w, input int offset_w);
        return addr_w - set_w - offset_w;
    endfunction

    typedef struct packed {
        logic [SLC_ADDR_W-1:0]  addr;
        logic [SLC_TXNID_W-1:0] txnid;
    } slc_lk_req_t;

    typedef struct packed {
        logic [SLC_TXNID_W-1:0] txnid;
        logic                   hit;
        logic [SLC_WAY_W-1:0]   way;
        logic [2:0]             state;
        logic                   victim_dirty;
        logic [SLC_ADDR_W-1:0]  victim_addr;
    } slc_lk_rsp_t;

endpackage

// File: rtl/slc_plru_tree.sv
// Combinational tree-PLRU: victim from the node bits, and the next node bits after touching a way.
// Nodes are heap-ordered (root = node 1 at bit 0); a node bit of 0 points left.
module slc_plru_tree #(
    parameter int WAYS = 4,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  plru_i,
    input  logic [WAY_W-1:0] touch_i,
    output logic [WAY_W-1:0] victim_o,
    output logic [WAYS-2:0]  plru_o
);

    always_comb begin
        int node;
        node = 1;
        for (int l = 0; l < WAY_W; l++) begin
            node = 2 * node + int'(plru_i[node-1]);
        end
        victim_o = WAY_W'(node - WAYS);
    end

    // Each node on the touched way's path is set to point at the other subtree.
    always_comb begin
        int   node;
        logic dir;
        plru_o = plru_i;
        node   = 1;
        for (int l = 0; l < WAY_W; l++) begin
            dir              = touch_i[WAY_W-1-l];
            plru_o[node-1]   = ~dir;
            node             = 2 * node + int'(dir);
        end
    end

endmodule

// File: rtl/slc_assoc.sv
// Set-associative SLC tag/state store with tree-PLRU victim selection.
// Post-reset sweep invalidates every set; lookups are answered from a single valid/ready output stage.
module slc_assoc
    import slc_pkg::*;
#(
    parameter int ADDR_W   = 48,
    parameter int OFFSET_W = 4,
    parameter int SET_W    = 7,
    parameter int WAYS     = 4,
    parameter int STATE_W  = 3,
    parameter int TXNID_W  = 8,
    localparam int TAG_W   = slc_tag_w(ADDR_W, SET_W, OFFSET_W),
    localparam int WAY_W   = $clog2(WAYS)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               init_done,
    input  logic               lk_valid,
    output logic               lk_ready,
    input  logic [ADDR_W-1:0]  lk_addr,
    input  logic [TXNID_W-1:0] lk_txnid,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [TXNID_W-1:0] rsp_txnid,
    output logic               rsp_hit,
    output logic [WAY_W-1:0]   rsp_way,
    output logic [STATE_W-1:0] rsp_state,
    output logic               rsp_victim_dirty,
    output logic [ADDR_W-1:0]  rsp_victim_addr,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [SET_W-1:0]   upd_set,
    input  logic [WAY_W-1:0]   upd_way,
    input  logic [TAG_W-1:0]   upd_tag,
    input  logic [STATE_W-1:0] upd_state,
    output logic               err_multi_hit
);

    localparam int SETS = 1 << SET_W;

    typedef enum logic {S_INIT, S_RUN} fsm_t;

    fsm_t              state_q, state_d;
    logic [SET_W-1:0]  cnt_q, cnt_d;

    // Tags are never cleared; only state and PLRU are swept.
    logic [TAG_W-1:0]   tag_arr  [SETS][WAYS];
    logic [STATE_W-1:0] st_arr   [SETS][WAYS];
    logic [WAYS-2:0]    plru_arr [SETS];

    logic               rsp_valid_q, rsp_valid_d;
    logic [TXNID_W-1:0] txn_q;
    logic [SET_W-1:0]   set_q;
    logic [TAG_W-1:0]   ltag_q;
    logic               err_q;

    logic run, lk_acc, rsp_hs, upd_fire;
    logic [WAYS-1:0]  match;
    int               nmatch;
    logic             hit_c, free_any;
    logic [WAY_W-1:0] hit_way, free_way, plru_vic, vic_way, res_way;
    logic [WAYS-2:0]  plru_hit_nxt, plru_upd_in, plru_upd_nxt;
    logic [WAY_W-1:0] vic_unused;
    logic             addr_unused;

    assign addr_unused = ^lk_addr[OFFSET_W-1:0];

    assign run       = (state_q == S_RUN);
    assign init_done = run;
    assign upd_ready = run;
    assign lk_ready  = run & (~rsp_valid_q | rsp_ready);
    assign lk_acc    = lk_valid & lk_ready;
    assign rsp_hs    = rsp_valid_q & rsp_ready;
    assign upd_fire  = upd_valid & run;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) state_d = S_RUN;
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        if (lk_acc)      rsp_valid_d = 1'b1;
        else if (rsp_hs) rsp_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            txn_q       <= '0;
            set_q       <= '0;
            ltag_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            if (lk_acc) begin
                txn_q  <= lk_txnid;
                set_q  <= lk_addr[OFFSET_W+SET_W-1:OFFSET_W];
                ltag_q <= lk_addr[ADDR_W-1:ADDR_W-TAG_W];
            end
            if (rsp_valid_q && nmatch > 1) err_q <= 1'b1;
        end
    end

    // Compare against live contents so a same-set update re-evaluates a held response.
    always_comb begin
        match    = '0;
        nmatch   = 0;
        hit_way  = '0;
        free_way = '0;
        free_any = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (is_valid(st_arr[set_q][w]) && tag_arr[set_q][w] == ltag_q) begin
                match[w] = 1'b1;
                hit_way  = WAY_W'(w);
                nmatch   = nmatch + 1;
            end
            if (!is_valid(st_arr[set_q][w])) begin
                free_any = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

    assign hit_c   = |match;
    assign vic_way = free_any ? free_way : plru_vic;
    assign res_way = hit_c ? hit_way : vic_way;

    slc_plru_tree #(.WAYS(WAYS)) u_plru_rsp (
        .plru_i  (plru_arr[set_q]),
        .touch_i (hit_way),
        .victim_o(plru_vic),
        .plru_o  (plru_hit_nxt)
    );

    // The update touch is layered on top of a same-cycle hit touch to the same set.
    assign plru_upd_in = (rsp_hs && hit_c && set_q == upd_set) ? plru_hit_nxt : plru_arr[upd_set];

    slc_plru_tree #(.WAYS(WAYS)) u_plru_upd (
        .plru_i  (plru_upd_in),
        .touch_i (upd_way),
        .victim_o(vic_unused),
        .plru_o  (plru_upd_nxt)
    );

    always_ff @(posedge clk) begin
        if (!run) begin
            for (int w = 0; w < WAYS; w++) st_arr[cnt_q][w] <= SLC_I;
            plru_arr[cnt_q] <= '0;
        end else begin
            if (rsp_hs && hit_c) plru_arr[set_q] <= plru_hit_nxt;
            if (upd_fire) begin
                tag_arr[upd_set][upd_way] <= upd_tag;
                st_arr[upd_set][upd_way]  <= upd_state;
                plru_arr[upd_set]         <= plru_upd_nxt;
            end
        end
    end

    assign rsp_valid        = rsp_valid_q;
    assign rsp_txnid        = rsp_valid_q ? txn_q : '0;
    assign rsp_hit          = rsp_valid_q & hit_c;
    assign rsp_way          = rsp_valid_q ? res_way : '0;
    assign rsp_state        = rsp_valid_q ? st_arr[set_q][res_way] : '0;
    assign rsp_victim_dirty = rsp_valid_q & ~hit_c & ~free_any & is_dirty(st_arr[set_q][plru_vic]);
    assign rsp_victim_addr  = rsp_valid_q ? {tag_arr[set_q][vic_way], set_q, {OFFSET_W{1'b0}}} : '0;
    assign err_multi_hit    = err_q;

endmodule

// File: tb/tb_slc_assoc.sv
// Scoreboard bench for slc_assoc: directed scenarios plus randomized traffic checked against
// a behavioural cache model (per-way tag/state lists and a path-based PLRU description).
module tb_slc_assoc;
    import slc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done, lk_valid, lk_ready, rsp_valid, rsp_ready;
    logic [47:0] lk_addr, rsp_victim_addr;
    logic [7:0]  lk_txnid, rsp_txnid;
    logic        rsp_hit, rsp_victim_dirty, upd_valid, upd_ready, err_multi_hit;
    logic [1:0]  rsp_way, upd_way;
    logic [2:0]  rsp_state, upd_state;
    logic [6:0]  upd_set;
    logic [36:0] upd_tag;

    slc_assoc dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_addr(lk_addr), .lk_txnid(lk_txnid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_txnid(rsp_txnid), .rsp_hit(rsp_hit),
        .rsp_way(rsp_way), .rsp_state(rsp_state), .rsp_victim_dirty(rsp_victim_dirty),
        .rsp_victim_addr(rsp_victim_addr), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_set(upd_set), .upd_way(upd_way), .upd_tag(upd_tag), .upd_state(upd_state),
        .err_multi_hit(err_multi_hit)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, rsp_cnt = 0;

    // Reference model
    logic [36:0] m_tag   [128][4];
    bit          m_known [128][4];
    logic [2:0]  m_st    [128][4];
    logic [2:0]  m_plru  [128];
    bit          exp_err;
    slc_lk_req_t pend[$];
    logic [7:0]  seen[$];
    slc_lk_rsp_t last;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [47:0] mk_addr(input logic [36:0] tag, input logic [6:0] set);
        return {tag, set, 4'h0};
    endfunction

    // Way w sits under heap nodes (4+w)>>k; it is the victim when every node on its path points at it.
    function automatic int m_victim(input logic [2:0] p);
        bit ok;
        int node, dir;
        for (int w = 0; w < 4; w++) begin
            ok = 1;
            for (int l = 0; l < 2; l++) begin
                node = (4 + w) >> (2 - l);
                dir  = ((4 + w) >> (1 - l)) & 1;
                if (int'(p[node-1]) != dir) ok = 0;
            end
            if (ok) return w;
        end
        return 0;
    endfunction

    function automatic void m_touch(input int set, input int w);
        int node, dir;
        for (int l = 0; l < 2; l++) begin
            node = (4 + w) >> (2 - l);
            dir  = ((4 + w) >> (1 - l)) & 1;
            m_plru[set][node-1] = (dir == 0);
        end
    endfunction

    function automatic void m_reset();
        for (int s = 0; s < 128; s++) begin
            m_plru[s] = '0;
            for (int w = 0; w < 4; w++) m_st[s][w] = SLC_I;
        end
        pend.delete();
        exp_err = 0;
    endfunction

    function automatic void model_eval(input slc_lk_req_t rq, output slc_lk_rsp_t e,
                                       output bit multi, output bit vknown);
        int set, cnt, v, fw;
        logic [36:0] tag;
        set = int'(rq.addr[10:4]);
        tag = rq.addr[47:11];
        cnt = 0; fw = -1;
        e = '0;
        e.txnid = rq.txnid;
        for (int w = 0; w < 4; w++) begin
            if (m_st[set][w] != SLC_I && m_tag[set][w] == tag) begin
                if (cnt == 0) e.way = 2'(w);
                cnt++;
            end
            if (m_st[set][w] == SLC_I && fw < 0) fw = w;
        end
        e.hit = (cnt > 0);
        multi = (cnt > 1);
        v = (fw >= 0) ? fw : m_victim(m_plru[set]);
        if (!e.hit) begin
            e.way = 2'(v);
            e.victim_dirty = (fw < 0) && m_st[set][v][1];
        end
        e.state = m_st[set][e.way];
        e.victim_addr = mk_addr(m_tag[set][v], 7'(set));
        vknown = m_known[set][v];
    endfunction

    // Monitor: samples one time unit before each rising edge.
    slc_lk_rsp_t mon_exp, mon_act;
    bit mon_multi, mon_vk, mon_ok;
    always @(negedge clk) begin
        #4;
        if (rst_n && init_done) begin
            chk("rsp_valid", rsp_valid, pend.size() != 0);
            chk("lk_ready", lk_ready, (pend.size() == 0) || rsp_ready);
            if (rsp_valid && pend.size() != 0) begin
                model_eval(pend[0], mon_exp, mon_multi, mon_vk);
                if (rsp_ready) begin
                    mon_act = '{txnid: rsp_txnid, hit: rsp_hit, way: rsp_way, state: rsp_state,
                                victim_dirty: rsp_victim_dirty, victim_addr: rsp_victim_addr};
                    mon_ok = mon_act.txnid === mon_exp.txnid && mon_act.hit === mon_exp.hit &&
                             mon_act.way === mon_exp.way && mon_act.state === mon_exp.state &&
                             mon_act.victim_dirty === mon_exp.victim_dirty &&
                             (mon_exp.hit || !mon_vk || mon_act.victim_addr === mon_exp.victim_addr);
                    n_chk++;
                    if (mon_ok) n_pass++;
                    else $display("FAIL rsp: got %h expected %h", mon_act, mon_exp);
                    chk("err_multi_hit", err_multi_hit, exp_err);
                    seen.push_back(rsp_txnid);
                    last = mon_act;
                    rsp_cnt++;
                    if (mon_exp.hit) m_touch(int'(pend[0].addr[10:4]), int'(mon_exp.way));
                    void'(pend.pop_front());
                end
                if (mon_multi) exp_err = 1;
            end
            if (upd_valid) begin
                chk("upd_ready", upd_ready, 1);
                m_tag[upd_set][upd_way]   = upd_tag;
                m_st[upd_set][upd_way]    = upd_state;
                m_known[upd_set][upd_way] = 1;
                m_touch(int'(upd_set), int'(upd_way));
            end
            if (lk_valid && lk_ready) pend.push_back('{addr: lk_addr, txnid: lk_txnid});
        end
    end

    // All tasks start and end one time unit after a rising edge.
    task automatic do_lookup(input logic [47:0] a, input logic [7:0] t, input bit lat, input bit wait_rsp);
        int start;
        bit acc;
        start = rsp_cnt;
        lk_valid = 1; lk_addr = a; lk_txnid = t;
        acc = 0;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk); #4;
            if (lk_ready) acc = 1;
        end
        @(posedge clk); #1;
        lk_valid = 0;
        if (!acc) chk("lk_accept_timeout", 0, 1);
        else if (lat) chk("rsp_latency", rsp_valid, 1);
        if (wait_rsp) begin
            for (int n = 0; n < 20 && rsp_cnt == start; n++) @(posedge clk);
            #1;
            if (rsp_cnt == start) chk("rsp_timeout", 0, 1);
        end
    endtask

    task automatic do_update(input logic [6:0] s, input logic [1:0] w, input logic [36:0] tg, input logic [2:0] st);
        upd_valid = 1; upd_set = s; upd_way = w; upd_tag = tg; upd_state = st;
        @(posedge clk); #1;
        upd_valid = 0;
    endtask

    task automatic wait_init(input string nm);
        int cyc;
        bit early;
        cyc = -1; early = 0;
        @(negedge clk); rst_n = 1;
        for (int i = 1; i <= 300 && cyc < 0; i++) begin
            @(posedge clk); #1;
            if (init_done) cyc = i;
            else if (lk_ready || upd_ready) early = 1;
        end
        chk({nm, "_cycles"}, cyc, 128);
        chk({nm, "_ready_early"}, early, 0);
    endtask

    logic [2:0] st_pool [5] = '{SLC_UC, SLC_UD, SLC_SC, SLC_SD, SLC_I};

    initial begin
        lk_valid = 0; lk_addr = '0; lk_txnid = '0; rsp_ready = 1;
        upd_valid = 0; upd_set = '0; upd_way = '0; upd_tag = '0; upd_state = '0;
        for (int s = 0; s < 128; s++) for (int w = 0; w < 4; w++) m_known[s][w] = 0;
        m_reset();
        #3;
        chk("reset_outs", {init_done, lk_ready, upd_ready, rsp_valid, err_multi_hit}, 0);
        chk("reset_data", {rsp_txnid, rsp_hit, rsp_way, rsp_state, rsp_victim_dirty, rsp_victim_addr}, 0);
        wait_init("init");

        // Cold miss after init
        do_lookup(48'h1230, 8'd1, 1, 1);
        chk("cold_miss", {last.hit, last.way, last.victim_dirty}, 0);

        // Install UD in set 0x23 way 2, then hit it
        do_update(7'h23, 2'd2, 37'h012345678, SLC_UD);
        do_lookup(mk_addr(37'h012345678, 7'h23), 8'd2, 1, 1);
        chk("hit_ud", {last.hit, last.way, last.state}, {1'b1, 2'd2, 3'b110});

        // PLRU eviction in set 5
        for (int w = 0; w < 4; w++) do_update(7'd5, 2'(w), 37'h500 + 37'(w), SLC_SD);
        do_lookup(mk_addr(37'h5FF, 7'd5), 8'd3, 1, 1);
        chk("plru_vic0", {last.hit, last.way, last.victim_dirty}, {1'b0, 2'd0, 1'b1});
        chk("plru_vaddr", last.victim_addr, mk_addr(37'h500, 7'd5));
        do_lookup(mk_addr(37'h500, 7'd5), 8'd4, 1, 1);
        chk("plru_hit0", {last.hit, last.way}, {1'b1, 2'd0});
        do_lookup(mk_addr(37'h5FF, 7'd5), 8'd5, 1, 1);
        chk("plru_vic2", {last.hit, last.way, last.victim_dirty}, {1'b0, 2'd2, 1'b1});

        // Back-to-back lookups with a 3-cycle consumer stall
        seen.delete();
        rsp_ready = 0;
        lk_valid = 1; lk_addr = mk_addr(37'h7, 7'd3); lk_txnid = 8'd10;
        @(posedge clk); #1;
        lk_txnid = 8'd11; lk_addr = mk_addr(37'h8, 7'd4);
        for (int i = 0; i < 3; i++) begin
            chk("stall_lk_ready", lk_ready, 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        lk_txnid = 8'd12; lk_addr = mk_addr(37'h7, 7'd3);
        @(posedge clk); #1;
        lk_txnid = 8'd13; lk_addr = mk_addr(37'h500, 7'd5);
        @(posedge clk); #1;
        lk_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("txn_order", {seen.size() == 4 ? {seen[0], seen[1], seen[2], seen[3]} : 32'h0},
            {8'd10, 8'd11, 8'd12, 8'd13});

        // Held miss in set 9 flips to hit after a fill
        rsp_ready = 0;
        do_lookup(mk_addr(37'h999, 7'd9), 8'd20, 1, 0);
        chk("held_miss", {rsp_valid, rsp_hit, rsp_way}, {1'b1, 1'b0, 2'd0});
        do_update(7'd9, 2'd1, 37'h999, SLC_UC);
        chk("held_flip", {rsp_valid, rsp_hit, rsp_way, rsp_state}, {1'b1, 1'b1, 2'd1, 3'b100});
        rsp_ready = 1;
        @(posedge clk); #1;
        chk("held_rsp", {last.txnid, last.hit}, {8'd20, 1'b1});

        // Multi-hit
        do_update(7'h11, 2'd1, 37'hABC, SLC_SC);
        do_update(7'h11, 2'd3, 37'hABC, SLC_SC);
        do_lookup(mk_addr(37'hABC, 7'h11), 8'd30, 1, 1);
        chk("multi_way", {last.hit, last.way}, {1'b1, 2'd1});
        chk("multi_err", err_multi_hit, 1);

        // Randomized traffic on a small set/tag pool
        for (int i = 0; i < 500; i++) begin
            lk_valid  = ($urandom_range(0, 1) == 1);
            lk_addr   = {37'h100 + 37'($urandom_range(0, 4)), 7'h40 + 7'($urandom_range(0, 3)), 4'($urandom)};
            lk_txnid  = 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            upd_valid = ($urandom_range(0, 9) < 3);
            upd_set   = 7'h40 + 7'($urandom_range(0, 3));
            upd_way   = 2'($urandom);
            upd_tag   = 37'h100 + 37'($urandom_range(0, 4));
            upd_state = st_pool[$urandom_range(0, 4)];
            @(posedge clk); #1;
        end
        lk_valid = 0; upd_valid = 0; rsp_ready = 1;
        repeat (4) @(posedge clk);
        #1;

        // Reset during a stall
        rsp_ready = 0;
        do_lookup(mk_addr(37'h500, 7'd5), 8'd40, 1, 0);
        #2;
        rst_n = 0;
        m_reset();
        #1;
        chk("async_drop", {rsp_valid, err_multi_hit, init_done, lk_ready}, 0);
        rsp_ready = 1;
        wait_init("reinit");
        do_lookup(mk_addr(37'h500, 7'd5), 8'd41, 1, 1);
        chk("reinit_miss", {last.hit, last.way, last.victim_dirty}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/slc_assoc.md
Name: slc_assoc

Overview:
- Parametrised, set-associative successor to the direct-mapped HN-F SLC tag/state store.
- Holds tag, CHI state and tree-PLRU bits per set, and answers one lookup per cycle behind a valid/ready pipeline stage.
- On a miss it nominates a victim way, with a dirty flag for writeback. A separate update port installs or changes lines.
- Sits between the POCQ head-entry scheduler (lookups, alongside the snoop-filter lookup) and the HN-F transaction FSM (fills and state changes). The data array is outside this block.

Parameters:
ADDR_W, 48, physical address width
OFFSET_W, 4, log2 line bytes
SET_W, 7, log2 number of sets
WAYS, 4, associativity; power of two, >= 2
STATE_W, 3, state field width (fixed encoding below)
TXNID_W, 8, tag carried with each lookup
TAG_W, ADDR_W-SET_W-OFFSET_W, derived; not overridable

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
init_done  out  1  high once the post-reset array sweep completes
lk_valid  in  1  lookup request valid
lk_ready  out  1  lookup accepted when lk_valid & lk_ready
lk_addr  in  ADDR_W  lookup address
lk_txnid  in  TXNID_W  opaque ID returned with the result
rsp_valid  out  1  lookup result valid
rsp_ready  in  1  result consumed when rsp_valid & rsp_ready
rsp_txnid  out  TXNID_W  ID of the lookup
rsp_hit  out  1  tag match in a non-I way
rsp_way  out  $clog2(WAYS)  hit way, else victim way
rsp_state  out  STATE_W  state of hit way, else victim state
rsp_victim_dirty  out  1  miss and the victim is valid and dirty
rsp_victim_addr  out  ADDR_W  {victim tag, set, zero offset}
upd_valid  in  1  install/modify request
upd_ready  out  1  = init_done
upd_set  in  SET_W  target set
upd_way  in  $clog2(WAYS)  target way
upd_tag  in  TAG_W  tag written
upd_state  in  STATE_W  state written; I invalidates
err_multi_hit  out  1  sticky: more than one valid way matched

Behaviour:
- State encoding: UC=100, UD=110, SC=000, SD=010, I=001. bit2 = unique, bit1 = dirty. Any value other than I is valid.
- Reset (async, rst_n=0): init_done=0, lk_ready=0, upd_ready=0, rsp_valid=0, err_multi_hit=0, sweep counter=0. All rsp_* data fields are 0.
- INIT state:
  - Entered on reset release.
  - Each cycle writes state=I in every way and PLRU=0 for set[counter], then increments the counter.
  - After 2^SET_W cycles, moves to RUN and init_done=1; init_done stays high until the next reset.
  - Tags are not cleared.
- RUN state:
  - lk_ready = ~rsp_valid | rsp_ready, giving full throughput with back-to-back lookups.
  - Accepted lookup is registered into the single output stage, so rsp_valid rises the cycle after acceptance.
  - Set index = addr[OFFSET_W+SET_W-1:OFFSET_W]; tag = addr[ADDR_W-1:ADDR_W-TAG_W].
  - Compare is combinational against live array contents while rsp_valid is held. The result is architecturally defined in the cycle of the rsp handshake.
  - rsp_* fields must stay stable while rsp_valid & ~rsp_ready unless an update hits the same set; the consumer samples only at the handshake.
- Hit: rsp_way = lowest matching way. If more than one valid way matches, err_multi_hit is set and stays set until reset.
- Miss, victim selection:
  - Lowest-index way in state I, if any, with rsp_victim_dirty=0.
  - Otherwise the tree-PLRU victim, with rsp_victim_dirty = victim state bit1.
  - rsp_victim_addr is reconstructed from the victim's stored tag.
- PLRU:
  - WAYS-1 bits per set, tree-PLRU; a node bit of 0 points left.
  - A "touch" flips the path bits to point away from the touched way.
  - Touch on a hit handshake: the hit way. Touch on an update: upd_way. A miss handshake does not touch.
- Update:
  - Applied at the clock edge when upd_valid & upd_ready: writes tag and state of (upd_set, upd_way) and touches PLRU.
  - Never stalls in RUN.
- Simultaneous update and rsp handshake:
  - rsp reflects pre-update contents.
  - If both touch the same set, the update's touch is applied last and wins.
- Update to the set currently held in the output stage without a handshake: the response recomputes next cycle with the new contents. This is intended; it lets a fill turn a pending miss into a hit.
- rst_n asserted mid-operation: the pending response is dropped immediately (rsp_valid=0 asynchronously) and INIT restarts from set 0.

Decomposition:
- Shared package slc_pkg:
  - state encodings (SLC_UC/UD/SC/SD/I as localparams, replacing the current `define set)
  - helpers is_valid(), is_dirty(), is_unique()
  - TAG_W derivation function
  - lookup request/response struct typedefs
- One sub-module: slc_plru_tree (parameter WAYS), which is combinational:
  - input: PLRU bits; output: victim way
  - input: PLRU bits + touch way; output: next PLRU bits
- The array, sweep FSM and pipeline stay in slc_assoc.

Test Plan:
- Reset then idle -> init_done rises exactly 128 cycles after rst_n release; lk_ready=0 before that; a lookup to 0x1230 afterwards gives rsp_hit=0, rsp_way=0, rsp_victim_dirty=0.
- Update set 0x23 way 2 tag T with UD, then lookup the matching address -> rsp_hit=1, rsp_way=2, rsp_state=110, one cycle after acceptance.
- Fill all 4 ways of set 5 in order 0,1,2,3 with SD, then miss to set 5 -> victim way 0, rsp_victim_dirty=1, rsp_victim_addr equals way 0's line address; hit way 0, then miss again -> victim way 2.
- Back-to-back lookups with rsp_ready held low 3 cycles -> lk_ready=0 during the stall, no response lost or duplicated, txnids returned in order.
- Lookup misses in set 9 and is held; update installs the matching tag the next cycle -> the response flips to hit with the updated state before the handshake.
- Write the same tag into ways 1 and 3 of one set, then look it up -> rsp_way=1 and err_multi_hit=1; rst_n pulse mid-stall -> rsp_valid and err_multi_hit drop asynchronously and INIT reruns.
